// File: rtl/ps2_scancode_decoder.sv
// PS/2 scancode set 2 parser: folds E0/F0 prefixes into key events, skips the
// Pause/Break tail, and queues events in a small show-ahead FIFO.
module ps2_scancode_decoder #(
  parameter int FIFO_DEPTH     = 4,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  input  logic       key_ready,
  output logic       key_valid,
  output logic [7:0] key_code,
  output logic       key_extended,
  output logic       key_break,
  output logic       fifo_overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0] TIMEOUT_ONE  = TW'(1);
  localparam logic [AW:0]   PTR_ONE      = (AW + 1)'(1);

  typedef enum logic [2:0] {IDLE, GOT_E0, GOT_F0, GOT_E0F0, PAUSE_SKIP} state_t;

  state_t          state;
  logic [2:0]      skip_cnt;
  logic [TW-1:0]   timeout_cnt;

  logic            push;
  logic [9:0]      push_data;
  logic            pref_ext;
  logic            pref_brk;

  assign pref_ext = (state == GOT_E0) || (state == GOT_E0F0);
  assign pref_brk = (state == GOT_F0) || (state == GOT_E0F0);

  always_comb begin
    push      = 1'b0;
    push_data = 10'd0;
    if (received_data_en && state != PAUSE_SKIP) begin
      case (received_data)
        8'hE0, 8'hF0: ;
        8'h00, 8'hAA, 8'hEE, 8'hFA, 8'hFC, 8'hFE, 8'hFF: ;
        8'hE1: begin
          push      = 1'b1;
          push_data = {2'b00, 8'hE1};
        end
        default: begin
          push      = 1'b1;
          push_data = {pref_brk, pref_ext, received_data};
        end
      endcase
    end
  end

  // A strobe always restarts the timeout, so it wins over an expiring count.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      skip_cnt    <= 3'd0;
      timeout_cnt <= '0;
    end else if (received_data_en) begin
      timeout_cnt <= '0;
      if (state == PAUSE_SKIP) begin
        if (skip_cnt <= 3'd1) begin
          state    <= IDLE;
          skip_cnt <= 3'd0;
        end else begin
          skip_cnt <= skip_cnt - 3'd1;
        end
      end else begin
        case (received_data)
          8'hE0:   state <= pref_brk ? GOT_E0F0 : GOT_E0;
          8'hF0:   state <= pref_ext ? GOT_E0F0 : GOT_F0;
          8'hE1: begin
            state    <= PAUSE_SKIP;
            skip_cnt <= 3'd7;
          end
          default: state <= IDLE;
        endcase
      end
    end else if (state != IDLE) begin
      if (timeout_cnt == TIMEOUT_LAST) begin
        state       <= IDLE;
        skip_cnt    <= 3'd0;
        timeout_cnt <= '0;
      end else begin
        timeout_cnt <= timeout_cnt + TIMEOUT_ONE;
      end
    end else begin
      timeout_cnt <= '0;
    end
  end

  logic [9:0]  mem [FIFO_DEPTH];
  logic [AW:0] wr_ptr;
  logic [AW:0] rd_ptr;
  logic        empty;
  logic        full;
  logic        pop;
  logic        do_write;
  logic [9:0]  head;

  assign empty    = (wr_ptr == rd_ptr);
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign pop      = !empty && key_ready;
  assign do_write = push && (!full || pop);
  assign head     = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge CLOCK_50) begin
    if (do_write) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      fifo_overflow <= 1'b0;
    end else begin
      if (do_write) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)      rd_ptr <= rd_ptr + PTR_ONE;
      fifo_overflow <= push && full && !pop;
    end
  end

  // Head fields are forced to zero while empty so stale storage never leaks out.
  assign key_valid    = !empty;
  assign key_code     = empty ? 8'h00 : head[7:0];
  assign key_extended = !empty && head[8];
  assign key_break    = !empty && head[9];

endmodule
